// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential fetch over req/ack, prefetch FIFO, redirect flush.
// Define IFQ_BYPASS_EN to let a response that lands on an empty queue reach decode in the ack cycle.
module ifetch_queue #(
  parameter int                  I_WIDTH  = 32,
  parameter int                  PC_WIDTH = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [I_WIDTH-1:0]  imem_rdata_i,
  output logic                instr_valid_o,
  output logic [I_WIDTH-1:0]  instr_o,
  output logic [PC_WIDTH-1:0] instr_pc_o,
  input  logic                instr_ready_i,
  output logic [PC_WIDTH-1:0] fetch_pc_o,
  output logic [1:0]          state_dbg_o
);

  // Handshakes: a memory transfer completes on a rising edge where imem_req_o && imem_ack_i;
  // req/addr are held from assertion until that edge. Decode takes the head on an edge where
  // instr_valid_o && instr_ready_i. A redirect overrides both in the same cycle.

  localparam int             AW     = $clog2(DEPTH);
  localparam logic [AW:0]    FULL   = (AW+1)'(DEPTH);
  localparam logic [1:0]     S_IDLE = 2'd0;
  localparam logic [1:0]     S_WAIT = 2'd1;
  localparam logic [1:0]     S_DROP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [I_WIDTH-1:0]  data_q [DEPTH];
  logic [PC_WIDTH-1:0] pc_q   [DEPTH];

  logic                redirect_pc_unused;
  logic [PC_WIDTH-1:0] redirect_aligned;
  logic                ack_ok;
  logic                bypass_hit;
  logic                bypass_take;
  logic                enq;
  logic                deq;
  logic                head_valid;

  assign redirect_aligned   = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
  assign redirect_pc_unused = ^redirect_pc_i[1:0];

  assign ack_ok     = (state_q == S_WAIT) && imem_ack_i && !redirect_valid_i;
  assign head_valid = (count_q != '0);

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = ack_ok && (count_q == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit && instr_ready_i;
  assign enq         = ack_ok && !bypass_take;
  assign deq         = head_valid && instr_ready_i && !redirect_valid_i;

  // Fetch FSM; in IDLE nothing is outstanding, so count alone decides whether a slot is free
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (!redirect_valid_i && (count_q < FULL)) begin
          state_d = S_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          state_d = S_IDLE;
          if (!redirect_valid_i) fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
        end else if (redirect_valid_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid_i) fetch_pc_d = redirect_aligned;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is reset so the head reads as zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (enq) begin
      data_q[wr_ptr_q] <= imem_rdata_i;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign imem_req_o    = (state_q != S_IDLE);
  assign imem_addr_o   = addr_q;
  assign fetch_pc_o    = fetch_pc_q;
  assign state_dbg_o   = state_q;
  assign instr_valid_o = head_valid || bypass_hit;
  assign instr_o       = bypass_hit ? imem_rdata_i : data_q[rd_ptr_q];
  assign instr_pc_o    = bypass_hit ? fetch_pc_q   : pc_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: random-latency memory, scoreboard of the expected in-order
// instruction stream, directed redirect/reset/wrap scenarios, then random traffic.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [31:0] fetch_pc;
  logic [1:0]  state_dbg;

  int          n_checks = 0;
  int          n_errors = 0;

  // Expected entries {pc, instr}, oldest first
  logic [63:0] exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  bit          drop_pending = 0;
  bit          prev_req = 0;
  bit          prev_ack = 0;
  logic [31:0] prev_addr = '0;
  int          push_n = 0;
  int          accept_n = 0;
  bit          saw_wrap = 0;
  logic [31:0] last_acc_pc = '0;

  int          force_lat = -1;
  int          lat_left = -1;
  bit          stale_req = 0;

  ifetch_queue #(
    .I_WIDTH (32),
    .PC_WIDTH(32),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .imem_rdata_i    (imem_rdata),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_ready_i   (instr_ready),
    .fetch_pc_o      (fetch_pc),
    .state_dbg_o     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      64'(imem_req),    64'd0);
    check({tag, "_addr"},     64'(imem_addr),   64'(RESET_PC));
    check({tag, "_valid"},    64'(instr_valid), 64'd0);
    check({tag, "_instr"},    64'(instr),       64'd0);
    check({tag, "_instr_pc"}, 64'(instr_pc),    64'd0);
    check({tag, "_fetch_pc"}, 64'(fetch_pc),    64'(RESET_PC));
  endtask

  task automatic wait_accepts(input int n, input int budget, input string name);
    int start;
    int c;
    start = accept_n;
    c = 0;
    while ((accept_n - start) < n && c < budget) begin
      tick();
      c++;
    end
    check(name, 64'((accept_n - start) >= n), 64'd1);
  endtask

  task automatic wait_new_request(input int budget, input string name, input logic [31:0] exp_addr);
    int c;
    c = 0;
    while (!(imem_req && !drop_pending) && c < budget) begin
      tick();
      c++;
    end
    check(name, 64'(imem_addr), 64'(exp_addr));
  endtask

  // ---------------- memory responder ----------------
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      imem_ack = 1'b0;
      lat_left = -1;
    end else if (stale_req) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      stale_req  = 0;
    end else if (imem_ack) begin
      imem_ack = 1'b0;
      lat_left = -1;
    end else if (imem_req) begin
      if (lat_left < 0) lat_left = (force_lat >= 0) ? force_lat : int'($urandom_range(3, 0));
      if (lat_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        lat_left   = -1;
      end else begin
        lat_left--;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [63:0] head;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      exp_q.delete();
      model_pc     = RESET_PC;
      drop_pending = 0;
      prev_req     = 0;
      prev_ack     = 0;
    end else begin
      check("fetch_pc", 64'(fetch_pc), 64'(model_pc));
      check("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("instr_pc", 64'(instr_pc), 64'(head[63:32]));
        check("instr", 64'(instr), 64'(head[31:0]));
      end
      check("space_bound", 64'((exp_q.size() + (imem_req ? 1 : 0)) <= DEPTH), 64'd1);
      if (prev_req && !prev_ack) begin
        check("req_held", 64'(imem_req), 64'd1);
        check("addr_held", 64'(imem_addr), 64'(prev_addr));
      end
      if (imem_req && !drop_pending) check("imem_addr", 64'(imem_addr), 64'(model_pc));

      if (redirect_valid) begin
        exp_q.delete();
        model_pc     = {redirect_pc[31:2], 2'b00};
        drop_pending = imem_req && !imem_ack;
      end else begin
        if (exp_q.size() != 0 && instr_ready) begin
          head = exp_q.pop_front();
          accept_n++;
          if (head[63:32] == 32'h0 && last_acc_pc == 32'hFFFF_FFFC) saw_wrap = 1;
          last_acc_pc = head[63:32];
        end
        if (imem_req && imem_ack) begin
          if (drop_pending) begin
            drop_pending = 0;
          end else begin
            exp_q.push_back({model_pc, mem_word(model_pc)});
            push_n++;
            model_pc = model_pc + 32'd4;
          end
        end
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Streaming with one-cycle memory and decode always ready
    force_lat   = 0;
    instr_ready = 1'b1;
    wait_accepts(8, 200, "stream_accepts");

    // Decode stalled: exactly DEPTH fetches, then the front end idles
    force_lat   = -1;
    instr_ready = 1'b0;
    push_n      = 0;
    do_redirect(32'h0);
    repeat (40) tick();
    check("stall_pushes", 64'(push_n), 64'(DEPTH));
    check("stall_req_idle", 64'(imem_req), 64'd0);
    check("stall_valid", 64'(instr_valid), 64'd1);
    check("stall_head_pc", 64'(instr_pc), 64'd0);
    instr_ready = 1'b1;
    c = 0;
    while (!imem_req && c < 20) begin
      tick();
      c++;
    end
    check("resume_addr", 64'(imem_addr), 64'h10);

    // Redirect while a slow request is outstanding
    instr_ready = 1'b0;
    force_lat   = 3;
    c = 0;
    while (!(imem_req && !imem_ack) && c < 20) begin
      tick();
      c++;
    end
    do_redirect(32'h103);
    check("drop_flush_valid", 64'(instr_valid), 64'd0);
    wait_new_request(20, "drop_next_addr", 32'h100);
    force_lat = -1;

    // Redirect in the same cycle as an ack with two entries queued
    do_redirect(32'h0);
    c = 0;
    while (!(exp_q.size() == 2 && imem_req && imem_ack) && c < 60) begin
      tick();
      c++;
    end
    check("ackredir_setup", 64'(exp_q.size()), 64'd2);
    do_redirect(32'h200);
    check("ackredir_valid", 64'(instr_valid), 64'd0);
    wait_new_request(20, "ackredir_next_addr", 32'h200);

    // Address wrap at the top of the PC space
    instr_ready = 1'b1;
    saw_wrap    = 0;
    do_redirect(32'hFFFF_FFF6);
    c = 0;
    while (!saw_wrap && c < 100) begin
      tick();
      c++;
    end
    check("pc_wrap", 64'(saw_wrap), 64'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      instr_ready    = ($urandom_range(99, 0) < 70);
      redirect_valid = ($urandom_range(99, 0) < 3);
      redirect_pc    = $urandom();
      tick();
    end
    redirect_valid = 1'b0;

    // Asynchronous reset mid-request with two entries queued
    instr_ready = 1'b0;
    do_redirect(32'h80);
    c = 0;
    while (!(exp_q.size() == 2 && imem_req && !imem_ack) && c < 60) begin
      tick();
      c++;
    end
    check("midreset_setup", 64'(exp_q.size()), 64'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) tick();
    @(negedge clk);
    rst_n     = 1'b1;
    stale_req = 1;
    instr_ready = 1'b1;
    wait_accepts(6, 100, "post_reset_accepts");
    check("post_reset_last_pc", 64'(last_acc_pc), 64'(RESET_PC + 32'd20));

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
